test_end_ctrl: RTL

Hardware end-of-test controller for the verification environment: arms on a start pulse, tracks per-channel done/fail indications from up to NUM_CH checkers, enforces an optional cycle timeout, and emits a single end-of-test pulse with a latched pass/fail/timeout verdict. It is the parametrised, multi-channel successor of the test package's single-flag wait-for-end mechanism. Testbench tops instantiate it alongside the DUT so simulation termination is decided by one block.

---
 rtl/test_end_ctrl_if.sv | 35 +++
 rtl/test_end_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/test_end_ctrl_if.sv
// Bus between a test bench top and the end-of-test controller: run configuration,
// per-channel checker status going in, verdict and progress coming out.
interface test_end_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int ID_W   = 8
);
    logic              start_i;
    logic [ID_W-1:0]   test_id_i;
    logic [CNT_W-1:0]  timeout_i;
    logic [NUM_CH-1:0] ch_en_i;
    logic [NUM_CH-1:0] ch_done_i;
    logic [NUM_CH-1:0] ch_fail_i;
    logic              busy_o;
    logic              end_of_test_o;
    logic              pass_o;
    logic              fail_o;
    logic              timeout_o;
    logic [NUM_CH-1:0] done_mask_o;
    logic [NUM_CH-1:0] fail_mask_o;
    logic [CNT_W-1:0]  cycles_o;
    logic [ID_W-1:0]   test_id_o;

    modport master (
        output start_i, test_id_i, timeout_i, ch_en_i, ch_done_i, ch_fail_i,
        input  busy_o, end_of_test_o, pass_o, fail_o, timeout_o,
               done_mask_o, fail_mask_o, cycles_o, test_id_o
    );

    modport slave (
        input  start_i, test_id_i, timeout_i, ch_en_i, ch_done_i, ch_fail_i,
        output busy_o, end_of_test_o, pass_o, fail_o, timeout_o,
               done_mask_o, fail_mask_o, cycles_o, test_id_o
    );
endinterface

// File: rtl/test_end_ctrl.sv
// End-of-test controller: arms on start, collects per-channel done/fail, applies an
// optional cycle timeout and issues one end pulse with a latched verdict.
module test_end_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int ID_W      = 8,
    parameter int FAIL_FAST = 0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    test_end_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  to_q, to_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] failm_q, failm_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              pass_q, pass_d;
    logic              vfail_q, vfail_d;
    logic              tmo_q, tmo_d;

    logic [NUM_CH-1:0] done_nx;
    logic [NUM_CH-1:0] failm_nx;
    logic [CNT_W-1:0]  cyc_nx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign done_nx  = done_q  | (bus.ch_done_i & en_q);
    assign failm_nx = failm_q | (bus.ch_fail_i & en_q);
    assign cyc_nx   = sat_inc(cyc_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        to_d    = to_q;
        en_d    = en_q;
        done_d  = done_q;
        failm_d = failm_q;
        cyc_d   = cyc_q;
        pass_d  = pass_q;
        vfail_d = vfail_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    id_d    = bus.test_id_i;
                    to_d    = bus.timeout_i;
                    en_d    = bus.ch_en_i;
                    done_d  = '0;
                    failm_d = '0;
                    cyc_d   = '0;
                    pass_d  = 1'b0;
                    vfail_d = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // An empty mask is a configuration error; it ends on the first RUN edge
                // without counting so the bench sees a fail with zero elapsed cycles.
                if (en_q == '0) begin
                    vfail_d = 1'b1;
                    state_d = DONE;
                end else begin
                    done_d  = done_nx;
                    failm_d = failm_nx;
                    cyc_d   = cyc_nx;
                    if ((done_nx & en_q) == en_q) begin
                        pass_d  = (failm_nx == '0);
                        vfail_d = (failm_nx != '0);
                        state_d = DONE;
                    end else if ((FAIL_FAST != 0) && (failm_nx != '0)) begin
                        vfail_d = 1'b1;
                        state_d = DONE;
                    end else if ((to_q != '0) && (cyc_nx == to_q)) begin
                        tmo_d   = 1'b1;
                        vfail_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            to_q    <= '0;
            en_q    <= '0;
            done_q  <= '0;
            failm_q <= '0;
            cyc_q   <= '0;
            pass_q  <= 1'b0;
            vfail_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            to_q    <= to_d;
            en_q    <= en_d;
            done_q  <= done_d;
            failm_q <= failm_d;
            cyc_q   <= cyc_d;
            pass_q  <= pass_d;
            vfail_q <= vfail_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.busy_o        = (state_q == RUN);
    assign bus.end_of_test_o = (state_q == DONE);
    assign bus.pass_o        = pass_q;
    assign bus.fail_o        = vfail_q;
    assign bus.timeout_o     = tmo_q;
    assign bus.done_mask_o   = done_q;
    assign bus.fail_mask_o   = failm_q;
    assign bus.cycles_o      = cyc_q;
    assign bus.test_id_o     = id_q;
endmodule
